// File: rtl/fcvt_s_w.sv
// fcvt_s_w: 3-stage int32 -> IEEE 754 single converter (abs, normalize, round-to-nearest-even).
// Optional macro FCVT_UNSIGNED_EN adds the is_unsigned input (fcvt.s.wu).
module fcvt_s_w (
  input  logic        clk,
  input  logic        reset,
  input  logic        in_valid,
  input  logic [31:0] rs1,
  input  logic        stall,
`ifdef FCVT_UNSIGNED_EN
  input  logic        is_unsigned,
`endif
  output logic        out_valid,
  output logic [31:0] out,
  output logic        out_nx
);

  // ---------------- Stage 1: sign / magnitude capture ----------------
  logic        w_s1_sign;
  logic [31:0] w_s1_mag;

`ifdef FCVT_UNSIGNED_EN
  assign w_s1_sign = rs1[31] & ~is_unsigned;
`else
  assign w_s1_sign = rs1[31];
`endif
  // Negating 0x80000000 wraps back to 0x80000000, which is the correct magnitude.
  assign w_s1_mag = w_s1_sign ? (~rs1 + 32'd1) : rs1;

  logic        r_s1_valid;
  logic        r_s1_sign;
  logic [31:0] r_s1_mag;

  always_ff @(posedge clk) begin
    if (reset) begin
      r_s1_valid <= 1'b0;
    end else if (!stall) begin
      r_s1_valid <= in_valid;
      r_s1_sign  <= w_s1_sign;
      r_s1_mag   <= w_s1_mag;
    end
  end

  // ---------------- Stage 2: leading-zero count and normalize ----------------
  logic [4:0]  w_lz;
  logic        w_found;
  logic [31:0] w_norm;
  logic [7:0]  w_exp;
  logic        w_zero;

  always_comb begin
    w_lz    = 5'd0;
    w_found = 1'b0;
    for (int i = 31; i >= 0; i--) begin
      if (!w_found && r_s1_mag[i]) begin
        w_lz    = 5'(31 - i);
        w_found = 1'b1;
      end
    end
  end

  assign w_zero = ~w_found;
  assign w_norm = r_s1_mag << w_lz;
  assign w_exp  = 8'd158 - {3'b000, w_lz};

  logic        r_s2_valid;
  logic        r_s2_sign;
  logic        r_s2_zero;
  logic [7:0]  r_s2_exp;
  logic [31:0] r_s2_norm;

  always_ff @(posedge clk) begin
    if (reset) begin
      r_s2_valid <= 1'b0;
    end else if (!stall) begin
      r_s2_valid <= r_s1_valid;
      r_s2_sign  <= r_s1_sign;
      r_s2_zero  <= w_zero;
      r_s2_exp   <= w_exp;
      r_s2_norm  <= w_norm;
    end
  end

  // ---------------- Stage 3: round to nearest even and pack ----------------
  logic [22:0] w_man;
  logic        w_guard;
  logic        w_sticky;
  logic        w_round_up;
  logic [23:0] w_man_inc;
  logic [7:0]  w_exp_rnd;
  logic [31:0] w_packed;

  assign w_man      = r_s2_norm[30:8];
  assign w_guard    = r_s2_norm[7];
  assign w_sticky   = |r_s2_norm[6:0];
  assign w_round_up = w_guard & (w_sticky | w_man[0]);
  assign w_man_inc  = {1'b0, w_man} + {23'd0, w_round_up};
  // A mantissa carry leaves the low 23 bits at zero, so only the exponent needs bumping.
  assign w_exp_rnd  = r_s2_exp + {7'd0, w_man_inc[23]};
  assign w_packed   = {r_s2_sign, w_exp_rnd, w_man_inc[22:0]};

  logic        r_out_valid;
  logic [31:0] r_out;
  logic        r_out_nx;

  always_ff @(posedge clk) begin
    if (reset) begin
      r_out_valid <= 1'b0;
      r_out       <= 32'd0;
      r_out_nx    <= 1'b0;
    end else if (!stall) begin
      r_out_valid <= r_s2_valid;
      if (r_s2_valid) begin
        r_out    <= r_s2_zero ? 32'd0 : w_packed;
        r_out_nx <= r_s2_zero ? 1'b0 : (w_guard | w_sticky);
      end
    end
  end

  assign out_valid = r_out_valid;
  assign out       = r_out;
  assign out_nx    = r_out_nx;

endmodule

// File: tb/tb_fcvt_s_w.sv
// Self-checking bench for fcvt_s_w: directed corner cases plus randomized traffic
// checked against an arithmetic reference of int32 -> float conversion.
module tb_fcvt_s_w;

  logic        clk;
  logic        reset;
  logic        in_valid;
  logic [31:0] rs1;
  logic        stall;
  logic        is_uns;
  logic        out_valid;
  logic [31:0] out;
  logic        out_nx;

  fcvt_s_w dut (
    .clk        (clk),
    .reset      (reset),
    .in_valid   (in_valid),
    .rs1        (rs1),
    .stall      (stall),
`ifdef FCVT_UNSIGNED_EN
    .is_unsigned(is_uns),
`endif
    .out_valid  (out_valid),
    .out        (out),
    .out_nx     (out_nx)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    int          due;
    logic [31:0] val;
    logic        nx;
  } pend_t;

  pend_t       exp_q[$];
  int          adv;
  logic        e_valid;
  logic [31:0] e_out;
  logic        e_nx;
  int          tests;
  int          fails;

  // Reference conversion from the numeric definition: find the top set bit,
  // drop the excess low bits, round half to even.
  function automatic void ref_conv(input logic [31:0] d, input bit uns,
                                   output logic [31:0] r, output logic nx);
    longint mag, q, rem, half;
    int     p, sh, e;
    bit     neg;
    neg = (d[31] == 1'b1) && !uns;
    mag = neg ? (64'sd4294967296 - longint'(d)) : longint'(d);
    nx  = 1'b0;
    if (mag == 0) begin
      r = 32'd0;
      return;
    end
    p = 0;
    for (int i = 0; i < 33; i++) if ((mag >> i) != 0) p = i;
    e = 127 + p;
    if (p <= 23) begin
      q = mag << (23 - p);
    end else begin
      sh   = p - 23;
      q    = mag >> sh;
      rem  = mag - (q << sh);
      half = longint'(1) << (sh - 1);
      nx   = (rem != 0);
      if (rem > half || (rem == half && q[0])) q = q + 1;
      if (q == (longint'(1) << 24)) begin
        q = q >> 1;
        e = e + 1;
      end
    end
    r = {neg, 8'(e), 23'(q)};
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    tests++;
    assert (obs === expv) else begin
      fails++;
      $error("FAIL %s: observed %h expected %h", tag, obs, expv);
    end
  endtask

  // One clock: drive inputs, take the edge, advance the model, compare outputs.
  // When have_exp is set the expected result is the given constant, otherwise the reference.
  task automatic step(input bit rst, input bit stl, input bit vld, input logic [31:0] d,
                      input bit uns, input bit have_exp, input logic [31:0] x_out,
                      input bit x_nx, input string tag);
    logic [31:0] r;
    logic        n;
    pend_t       pe;
    reset    = rst;
    stall    = stl;
    in_valid = vld;
    rs1      = d;
    is_uns   = uns;
    @(posedge clk);
    #1;
    if (rst) begin
      exp_q.delete();
      e_valid = 1'b0;
      e_out   = 32'd0;
      e_nx    = 1'b0;
    end else if (!stl) begin
      adv++;
      if (vld) begin
        if (have_exp) begin
          r = x_out;
          n = x_nx;
        end else begin
          ref_conv(d, uns, r, n);
        end
        pe.due = adv + 2;
        pe.val = r;
        pe.nx  = n;
        exp_q.push_back(pe);
      end
      e_valid = 1'b0;
      if (exp_q.size() > 0 && exp_q[0].due == adv) begin
        pe      = exp_q.pop_front();
        e_valid = 1'b1;
        e_out   = pe.val;
        e_nx    = pe.nx;
      end
    end
    chk({tag, ".valid"}, {31'd0, out_valid}, {31'd0, e_valid});
    chk({tag, ".out"},   out,                e_out);
    chk({tag, ".nx"},    {31'd0, out_nx},    {31'd0, e_nx});
    if (out_valid) $display("[TB] t=%0t %s result %h nx=%0b", $time, tag, out, out_nx);
  endtask

  initial begin
    tests = 0; fails = 0; adv = 0;
    e_valid = 1'b0; e_out = 32'd0; e_nx = 1'b0;
    reset = 1'b1; stall = 1'b0; in_valid = 1'b0; rs1 = 32'd0; is_uns = 1'b0;

    step(1, 0, 0, 0, 0, 0, 0, 0, "reset0");
    step(1, 0, 1, 32'h1234_5678, 0, 0, 0, 0, "reset1");

    // Back-to-back +1 / -1, then corner values
    step(0, 0, 1, 32'h0000_0001, 0, 1, 32'h3F80_0000, 0, "one");
    step(0, 0, 1, 32'hFFFF_FFFF, 0, 1, 32'hBF80_0000, 0, "minus_one");
    step(0, 0, 1, 32'h8000_0000, 0, 1, 32'hCF00_0000, 0, "int_min");
    step(0, 0, 1, 32'h0000_0000, 0, 1, 32'h0000_0000, 0, "zero");
    step(0, 0, 1, 32'h7FFF_FFFF, 0, 1, 32'h4F00_0000, 1, "int_max");
    step(0, 0, 1, 32'h0100_0001, 0, 1, 32'h4B80_0000, 1, "tie_down");
    step(0, 0, 1, 32'h0100_0003, 0, 1, 32'h4B80_0002, 1, "tie_up");
`ifdef FCVT_UNSIGNED_EN
    step(0, 0, 1, 32'hFFFF_FFFF, 1, 1, 32'h4F80_0000, 1, "u_max");
    step(0, 0, 1, 32'h8000_0000, 1, 1, 32'h4F00_0000, 0, "u_msb");
`endif
    for (int i = 0; i < 3; i++) step(0, 0, 0, 0, 0, 0, 0, 0, "drain");

    // Three in flight, then a four-cycle stall with input noise that must be ignored
    step(0, 0, 1, 32'd100, 0, 0, 0, 0, "st_a");
    step(0, 0, 1, 32'hFFFF_FF9C, 0, 0, 0, 0, "st_b");
    step(0, 0, 1, 32'd16777217, 0, 0, 0, 0, "st_c");
    for (int i = 0; i < 4; i++) step(0, 1, 1, 32'hDEAD_BEEF, 0, 0, 0, 0, "stall");
    for (int i = 0; i < 4; i++) step(0, 0, 0, 0, 0, 0, 0, 0, "st_drain");

    // Reset with two operations in flight: nothing stale may emerge afterwards
    step(0, 0, 1, 32'd7, 0, 0, 0, 0, "rf_a");
    step(0, 0, 1, 32'd9, 0, 0, 0, 0, "rf_b");
    step(1, 0, 0, 0, 0, 0, 0, 0, "rf_reset");
    step(0, 0, 1, 32'd3, 0, 1, 32'h4040_0000, 0, "post_reset");
    for (int i = 0; i < 4; i++) step(0, 0, 0, 0, 0, 0, 0, 0, "rf_drain");

    // Randomized traffic with bubbles and stalls
    for (int i = 0; i < 300; i++) begin
      logic [31:0] d;
      bit          u;
      d = $urandom;
      if ($urandom_range(0, 2) == 0) d = d >> $urandom_range(0, 31);
`ifdef FCVT_UNSIGNED_EN
      u = ($urandom_range(0, 1) == 1);
`else
      u = 1'b0;
`endif
      step(0, ($urandom_range(0, 7) == 0), ($urandom_range(0, 3) != 0), d, u, 0, 0, 0, "rand");
    end
    for (int i = 0; i < 4; i++) step(0, 0, 0, 0, 0, 0, 0, 0, "final_drain");

    tests++;
    assert (exp_q.size() == 0) else begin
      fails++;
      $error("FAIL leftover: observed %0d pending results expected 0", exp_q.size());
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/fcvt_s_w.md
FCVT_S_W -- requirements
Module: fcvt_s_w

Interface
REQ-001 SHALL have port clk  input  1  rising-edge clock for all state.
REQ-002 SHALL have port reset  input  1  synchronous, active-high reset.
REQ-003 SHALL have port in_valid  input  1  operand on rs1 is valid this cycle.
REQ-004 SHALL have port rs1  input  32  two's-complement integer operand, or unsigned when FCVT_UNSIGNED_EN is on and is_unsigned=1.
REQ-005 SHALL have port stall  input  1  when 1, all pipeline registers hold their values.
REQ-006 SHALL have port out_valid  output  1  out/out_nx hold a completed conversion.
REQ-007 SHALL have port out  output  32  IEEE 754 single-precision result {sign, exp[7:0], man[22:0]}.
REQ-008 SHALL have port out_nx  output  1  inexact flag: result was rounded.
REQ-009 SHALL have port is_unsigned  input  1  treat rs1 as unsigned; present only with FCVT_UNSIGNED_EN.

Function
REQ-010 SHALL be a 3-stage pipeline: S1 sign/abs capture, S2 leading-zero count plus normalize shift, S3 round and pack; every output is a register.
REQ-011 SHALL assert out_valid exactly 3 un-stalled cycles after in_valid=1 is sampled, with the matching out/out_nx.
REQ-012 SHALL accept one operand per cycle when stall=0, giving a throughput of 1 result per cycle.
REQ-013 SHALL, while stall=1, hold every stage register (valid bits included), ignore in_valid/rs1, and hold out/out_valid/out_nx unchanged.
REQ-014 SHALL compute sign = rs1[31] for signed operands and 0 for unsigned operands.
REQ-015 SHALL compute mag = |rs1| as a 32-bit unsigned value; signed 0x80000000 gives mag 0x80000000.
REQ-016 SHALL compute lz = count of leading zeros of mag (0..31), and norm = mag << lz, so norm[31]=1.
REQ-017 SHALL form exp = 158 - lz (that is, 127+31-lz), mantissa = norm[30:8], guard = norm[7], sticky = OR of norm[6:0].
REQ-018 SHALL round to nearest, ties to even: increment the mantissa when guard & (sticky | mantissa[0]).
REQ-019 SHALL, on mantissa carry-out, set mantissa=0 and exp=exp+1; exp never exceeds 159, so no overflow or infinity is possible.
REQ-020 SHALL set out_nx = guard | sticky.
REQ-021 SHALL map mag=0 to out=0x00000000 (+0.0) with out_nx=0, regardless of sign.
REQ-022 SHALL carry bubbles (in_valid=0) through the pipeline as out_valid=0; out holds its last value during bubbles.

Reset
REQ-023 SHALL, when reset=1 at a clock edge, clear all stage valid bits, out_valid, out and out_nx to 0; reset has priority over stall.
REQ-024 SHALL discard any in-flight operations on reset; no out_valid SHALL appear for operands accepted before reset.
REQ-025 SHALL accept a new operand on the first edge where reset=0, with a result 3 cycles later.

Configuration
REQ-026 SHALL, with macro FCVT_UNSIGNED_EN defined, include the is_unsigned input, pipelined alongside the operand, implementing fcvt.s.wu when is_unsigned=1.
REQ-027 SHALL, without FCVT_UNSIGNED_EN, omit the is_unsigned port and always treat rs1 as signed (fcvt.s.w only).

Verification
REQ-028 SHALL cover: rs1=1, then rs1=0xFFFFFFFF (-1) back-to-back -> out=0x3F800000 then 0xBF800000 on consecutive cycles, 3 cycles after each input, nx=0.
REQ-029 SHALL cover: rs1=0x80000000 signed -> 0xCF000000, nx=0; rs1=0 -> 0x00000000, nx=0.
REQ-030 SHALL cover: rs1=0x7FFFFFFF -> 0x4F000000, nx=1 (carry into exp); rs1=0x01000001 -> 0x4B800000, nx=1 (tie to even, rounds down); rs1=0x01000003 -> 0x4B800002, nx=1 (tie, rounds up).
REQ-031 SHALL cover, with FCVT_UNSIGNED_EN: is_unsigned=1, rs1=0xFFFFFFFF -> 0x4F800000, nx=1; is_unsigned=1, rs1=0x80000000 -> 0x4F000000, nx=0.
REQ-032 SHALL cover: 3 valid inputs, stall=1 for 4 cycles mid-flight -> outputs frozen during the stall, all 3 results in order afterwards, none lost or duplicated.
REQ-033 SHALL cover: reset=1 for 1 cycle with 2 operations in flight -> out_valid=0 and out=0 on the next cycle, and no stale results appear afterwards.
